// File: rtl/nand_pkg.sv
// Shared opcodes, state/selector encodings and ID bytes for the NAND target emulator.
package nand_pkg;

  localparam logic [7:0] CMD_READ     = 8'h00;
  localparam logic [7:0] CMD_READ_CFM = 8'h30;
  localparam logic [7:0] CMD_PROG     = 8'h80;
  localparam logic [7:0] CMD_PROG_CFM = 8'h10;
  localparam logic [7:0] CMD_ID       = 8'h90;
  localparam logic [7:0] CMD_STATUS   = 8'h70;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam int unsigned ADDR_CYCLES       = 5;
  localparam int unsigned ID_LEN            = 5;
  localparam int unsigned RESET_BUSY_CYCLES = 8;

  localparam logic [7:0] ID_0 = 8'h2C;
  localparam logic [7:0] ID_1 = 8'hDA;
  localparam logic [7:0] ID_2 = 8'h90;
  localparam logic [7:0] ID_3 = 8'h95;
  localparam logic [7:0] ID_4 = 8'h06;

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_WAIT_CFM, ST_DIN, ST_BUSY, ST_DOUT} state_t;
  typedef enum logic [1:0] {SEL_PAGE, SEL_ID, SEL_STATUS} out_sel_t;
  typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ID} op_t;
  typedef enum logic [1:0] {BK_READ, BK_PROG, BK_RESET} busy_kind_t;

  function automatic logic [7:0] id_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return ID_0;
      3'd1:    return ID_1;
      3'd2:    return ID_2;
      3'd3:    return ID_3;
      default: return ID_4;
    endcase
  endfunction

endpackage

// File: rtl/nand_pin_sync.sv
// Two-flop synchronizers for the flash pins and DIO, plus strobe edge pulses gated by nCE.
module nand_pin_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       F_nCE,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_nWE,
  input  logic       F_nRE,
  input  logic       F_nWP,
  input  logic [7:0] dio_in,
  output logic       nce,
  output logic       cle,
  output logic       ale,
  output logic       nre,
  output logic       nwp,
  output logic [7:0] dio,
  output logic       we_rise,
  output logic       re_fall,
  output logic       re_rise
);

  // Order: nCE, CLE, ALE, nWE, nRE, nWP; idle levels so no edge fires out of reset.
  localparam logic [5:0] PIN_IDLE = 6'b100111;

  logic [5:0] pins_s1, pins_s2;
  logic [7:0] dio_s1;
  logic       nwe, we_prev, re_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pins_s1 <= PIN_IDLE;
      pins_s2 <= PIN_IDLE;
      dio_s1  <= '0;
      dio     <= '0;
      we_prev <= 1'b1;
      re_prev <= 1'b1;
    end else begin
      pins_s1 <= {F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP};
      pins_s2 <= pins_s1;
      dio_s1  <= dio_in;
      dio     <= dio_s1;
      we_prev <= nwe;
      re_prev <= nre;
    end
  end

  assign {nce, cle, ale, nwe, nre, nwp} = pins_s2;

  assign we_rise = ~nce & nwe & ~we_prev;
  assign re_fall = ~nce & ~nre & re_prev;
  assign re_rise = ~nce & nre & ~re_prev;

endmodule

// File: rtl/nand_target_emu.sv
// NAND flash target emulator: decodes controller strobes, runs read/program/ID/status/reset
// against an internal page array and drives DIO and R/nB.
module nand_target_emu
  import nand_pkg::*;
#(
  parameter int unsigned PAGE_BYTES  = 64,
  parameter int unsigned PAGES       = 16,
  parameter int unsigned BUSY_CYCLES = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       F_nCE,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_nWE,
  input  logic       F_nRE,
  input  logic       F_nWP,
  input  logic [7:0] dio_in,
  output logic [7:0] dio_out,
  output logic       dio_oe,
  output logic       F_nRB
);

  localparam int unsigned CW = $clog2(PAGE_BYTES);
  localparam int unsigned RW = $clog2(PAGES);
  localparam int unsigned BW = $clog2(BUSY_CYCLES);

  logic       nce, cle, ale, nre, nwp;
  logic       we_rise, re_fall, re_rise;
  logic [7:0] dio;

  state_t     state_q, state_d;
  out_sel_t   out_sel;
  op_t        op;
  busy_kind_t busy_kind;

  logic [2:0]    addr_cnt;
  logic [2:0]    id_idx;
  logic [CW-1:0] col, ptr, cp;
  logic [RW-1:0] row;
  logic [BW-1:0] busy_cnt;
  logic          fail, copy_on;

  logic [7:0] page_buf [PAGE_BYTES];
  logic [7:0] mem      [PAGES*PAGE_BYTES];

  logic       cmd_ev, addr_ev, data_ev;
  logic       go_status, go_reset, go_read, go_prog, begin_op;
  logic       take_addr, take_data, busy_done, copy_rd, copy_wr;
  logic [7:0] status, out_byte;

  nand_pin_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .F_nCE   (F_nCE),
    .F_CLE   (F_CLE),
    .F_ALE   (F_ALE),
    .F_nWE   (F_nWE),
    .F_nRE   (F_nRE),
    .F_nWP   (F_nWP),
    .dio_in  (dio_in),
    .nce     (nce),
    .cle     (cle),
    .ale     (ale),
    .nre     (nre),
    .nwp     (nwp),
    .dio     (dio),
    .we_rise (we_rise),
    .re_fall (re_fall),
    .re_rise (re_rise)
  );

  assign cmd_ev  = we_rise & cle & ~ale;
  assign addr_ev = we_rise & ale & ~cle;
  assign data_ev = we_rise & ~cle & ~ale;

  assign status  = {nwp, F_nRB, F_nRB, 4'b0000, fail};
  assign dio_oe  = ~nce & ~nre;
  assign copy_rd = copy_on & (busy_kind == BK_READ);
  assign copy_wr = copy_on & (busy_kind == BK_PROG);

  always_comb begin
    case (out_sel)
      SEL_PAGE: out_byte = page_buf[ptr];
      SEL_ID:   out_byte = id_byte(id_idx);
      default:  out_byte = status;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Reset and status are honoured everywhere; busy then ignores everything else, including nCE.
  always_comb begin
    state_d   = state_q;
    go_status = cmd_ev && (dio == CMD_STATUS);
    go_reset  = cmd_ev && (dio == CMD_RESET);
    go_read   = 1'b0;
    go_prog   = 1'b0;
    begin_op  = 1'b0;
    take_addr = 1'b0;
    take_data = 1'b0;
    busy_done = 1'b0;
    if (go_reset) begin
      state_d = ST_BUSY;
    end else if (state_q == ST_BUSY) begin
      if (busy_cnt == '0) begin
        busy_done = 1'b1;
        state_d   = (busy_kind == BK_READ) ? ST_DOUT : ST_IDLE;
      end
    end else if (nce) begin
      state_d = ST_IDLE;
    end else if (cmd_ev) begin
      case (dio)
        CMD_STATUS: ;
        CMD_READ, CMD_PROG, CMD_ID: begin
          begin_op = 1'b1;
          state_d  = ST_ADDR;
        end
        CMD_READ_CFM: begin
          if (state_q == ST_WAIT_CFM) begin
            go_read = 1'b1;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        CMD_PROG_CFM: begin
          if (state_q == ST_DIN) begin
            go_prog = 1'b1;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (addr_ev) begin
      if (state_q == ST_ADDR) begin
        take_addr = 1'b1;
        if (op == OP_ID)
          state_d = ST_DOUT;
        else if (addr_cnt == 3'(ADDR_CYCLES - 1))
          state_d = (op == OP_READ) ? ST_WAIT_CFM : ST_DIN;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (data_ev) begin
      if (state_q == ST_DIN) take_data = 1'b1;
      else                   state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dio_out   <= '0;
      F_nRB     <= 1'b1;
      out_sel   <= SEL_STATUS;
      op        <= OP_READ;
      busy_kind <= BK_RESET;
      fail      <= 1'b0;
      copy_on   <= 1'b0;
      addr_cnt  <= '0;
      id_idx    <= '0;
      col       <= '0;
      row       <= '0;
      ptr       <= '0;
      cp        <= '0;
      busy_cnt  <= '0;
    end else begin
      if (go_reset) begin
        fail      <= 1'b0;
        col       <= '0;
        row       <= '0;
        F_nRB     <= 1'b0;
        busy_cnt  <= BW'(RESET_BUSY_CYCLES - 1);
        busy_kind <= BK_RESET;
        copy_on   <= 1'b0;
      end else if (state_q == ST_BUSY) begin
        if (busy_done) begin
          F_nRB <= 1'b1;
          if (busy_kind == BK_READ) begin
            out_sel <= SEL_PAGE;
            ptr     <= col;
          end
        end else begin
          busy_cnt <= busy_cnt - 1'b1;
        end
        if (copy_on) begin
          cp <= cp + 1'b1;
          if (cp == CW'(PAGE_BYTES - 1)) copy_on <= 1'b0;
        end
      end

      if (go_read || go_prog) begin
        F_nRB     <= 1'b0;
        busy_cnt  <= BW'(BUSY_CYCLES - 1);
        busy_kind <= go_read ? BK_READ : BK_PROG;
        cp        <= '0;
        copy_on   <= go_read | nwp;
        if (go_prog && !nwp) fail <= 1'b1;
      end

      if (begin_op) begin
        op       <= (dio == CMD_READ) ? OP_READ : (dio == CMD_PROG) ? OP_PROG : OP_ID;
        addr_cnt <= '0;
      end

      // Address bytes land at their byte lane; lanes beyond the column/row width fall away.
      if (take_addr && op != OP_ID) begin
        case (addr_cnt)
          3'd0:    col <= CW'(dio);
          3'd1:    col <= (col & CW'(8'hFF)) | CW'({dio, 8'h00});
          3'd2:    row <= RW'(dio);
          3'd3:    row <= (row & RW'(8'hFF)) | RW'({dio, 8'h00});
          default: row <= (row & RW'(16'hFFFF)) | RW'({dio, 16'h0000});
        endcase
        addr_cnt <= addr_cnt + 1'b1;
        if (addr_cnt == 3'(ADDR_CYCLES - 1)) ptr <= col;
      end

      if (take_addr && op == OP_ID) begin
        out_sel <= SEL_ID;
        id_idx  <= '0;
      end

      if (take_data) ptr <= ptr + 1'b1;

      if (re_rise && state_q == ST_DOUT) begin
        if (out_sel == SEL_PAGE)
          ptr <= ptr + 1'b1;
        else if (out_sel == SEL_ID)
          id_idx <= (id_idx == 3'(ID_LEN - 1)) ? '0 : id_idx + 1'b1;
      end

      if (re_fall) dio_out <= out_byte;

      if (go_status) out_sel <= SEL_STATUS;
    end
  end

  always_ff @(posedge clk) begin
    if (take_data) page_buf[ptr]  <= dio;
    if (copy_rd)   page_buf[cp]   <= mem[{row, cp}];
    if (copy_wr)   mem[{row, cp}] <= page_buf[cp];
  end

endmodule
